// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
// Holds the FSM state enum, the winner encoding, the cell index type and the one-hot cell mask helper.
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;

  typedef logic [3:0] cell_idx_t;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_X     = 2'b01;
  localparam logic [1:0] WIN_O     = 2'b10;
  localparam logic [1:0] WIN_FAULT = 2'b11;

  // Indices 9..15 shift the single bit out of the mask, so they map to an all-zero mask.
  function automatic logic [NUM_CELLS-1:0] cell_mask(cell_idx_t idx);
    logic [NUM_CELLS-1:0] one;
    one = {{(NUM_CELLS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/tictactoe_turn_timer.sv
// Idle-turn counter: counts consecutive run cycles and flags the one that reaches TIMEOUT_CYCLES.
// Latency: expire is combinational in the cycle the count is reached; the counter self-clears then.
// Backpressure: none; a low run clears the count.
module tictactoe_turn_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tictactoe_board_ctrl.sv
// Board controller: accepts moves, owns X/O boards and turn, resolves the game from the external checker.
// Latency: ack/rej in T+1, game_over/winner in T+2; TURN_TIMEOUT_EN adds an idle-turn forfeit pulse.
// Backpressure: move_ready is low in CHECK and OVER and whenever new_game is asserted.
module tictactoe_board_ctrl
  import tictactoe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_ack,
  output logic       move_rej,
  output logic [8:0] x,
  output logic [8:0] o,
  output logic       turn,
  input  logic       chk_error,
  input  logic       chk_full,
  input  logic       chk_win_x,
  input  logic       chk_win_o,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e               state;
  cell_idx_t            pos;
  logic [15:0]          occ_ext;
  logic [NUM_CELLS-1:0] place;
  logic                 hs;
  logic                 legal;
  logic                 accept;
  logic                 expire;

  assign pos        = move_pos;
  assign move_ready = (state == PLAY) && !new_game;
  assign hs         = move_valid && move_ready;
  // Zero-extend occupancy so out-of-range indices read as free; range check rejects them anyway.
  assign occ_ext    = {7'b0, x | o};
  assign legal      = (pos <= 4'd8) && !occ_ext[pos];
  assign accept     = hs && legal;
  assign place      = cell_mask(pos);

`ifdef TURN_TIMEOUT_EN
  logic run;

  // Counts PLAY cycles without an accepted move; a move in the expiry cycle takes priority.
  assign run = move_ready && !accept;

  tictactoe_turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      x         <= '0;
      o         <= '0;
      turn      <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      move_ack  <= 1'b0;
      move_rej  <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      move_rej <= 1'b0;
      if (new_game) begin
        state     <= PLAY;
        x         <= '0;
        o         <= '0;
        turn      <= 1'b0;
        game_over <= 1'b0;
        winner    <= WIN_NONE;
      end else begin
        case (state)
          PLAY: begin
            if (accept) begin
              if (turn) o <= o | place;
              else      x <= x | place;
              move_ack <= 1'b1;
              state    <= CHECK;
            end else begin
              move_rej <= hs;
              if (expire) turn <= ~turn;
            end
          end
          CHECK: begin
            if (chk_error) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= WIN_FAULT;
            end else if (chk_win_x) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= WIN_X;
            end else if (chk_win_o) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= WIN_O;
            end else if (chk_full) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= WIN_NONE;
            end else begin
              state <= PLAY;
              turn  <= ~turn;
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: state <= PLAY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Bench for tictactoe_board_ctrl: directed game scenarios plus randomized play against a board-level model.
// Build with TURN_TIMEOUT_EN defined to cover the idle-turn forfeit path (TIMEOUT_CYCLES = 4).
module tb_tictactoe_board_ctrl;

  localparam int TO = 4;
  localparam int LINES [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                                  '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       move_ack;
  logic       move_rej;
  logic [8:0] x;
  logic [8:0] o;
  logic       turn;
  logic       chk_error;
  logic       chk_full;
  logic       chk_win_x;
  logic       chk_win_o;
  logic       game_over;
  logic [1:0] winner;
  logic       timeout;
  logic       force_err;

  int n_cmp;
  int n_fail;

  // Reference model: board as cells (0 empty, 1 X, 2 O), phase 0 play / 1 check / 2 over.
  int  m_b [9];
  int  m_phase;
  int  m_win;
  int  m_idle;
  bit  m_turn;
  bit  m_over;
  bit  m_ack;
  bit  m_rej;
  bit  m_to;
  bit  obs_ready;
  bit  exp_ready;
`ifdef TURN_TIMEOUT_EN
  bit  to_en = 1'b1;
`else
  bit  to_en = 1'b0;
`endif

  always #5 clk = ~clk;

  tictactoe_board_ctrl #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .move_ack   (move_ack),
    .move_rej   (move_rej),
    .x          (x),
    .o          (o),
    .turn       (turn),
    .chk_error  (chk_error),
    .chk_full   (chk_full),
    .chk_win_x  (chk_win_x),
    .chk_win_o  (chk_win_o),
    .game_over  (game_over),
    .winner     (winner),
    .timeout    (timeout)
  );

  function automatic bit has_line(logic [8:0] b);
    for (int i = 0; i < 8; i++)
      if (b[LINES[i][0]] && b[LINES[i][1]] && b[LINES[i][2]]) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural stand-in for the external combinational checker.
  assign chk_win_x = has_line(x);
  assign chk_win_o = has_line(o);
  assign chk_full  = &(x | o);
  assign chk_error = force_err | (|(x & o));

  function automatic logic [8:0] mmask(int who);
    logic [8:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) m[i] = (m_b[i] == who);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_b[i] = 0;
    m_phase = 0; m_win = 0; m_idle = 0; m_turn = 1'b0; m_over = 1'b0;
    m_ack = 1'b0; m_rej = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input bit ng, input bit mv, input int p, input bit fe);
    bit ok;
    m_ack = 1'b0; m_rej = 1'b0; m_to = 1'b0;
    if (ng) begin
      model_reset();
    end else if (m_phase == 0) begin
      ok = 1'b0;
      if (mv && p <= 8) ok = (m_b[p] == 0);
      if (ok) begin
        m_b[p] = m_turn ? 2 : 1;
        m_ack = 1'b1; m_phase = 1; m_idle = 0;
      end else begin
        m_rej = mv;
        if (to_en) begin
          if (m_idle + 1 == TO) begin
            m_to = 1'b1; m_turn = !m_turn; m_idle = 0;
          end else begin
            m_idle++;
          end
        end
      end
    end else if (m_phase == 1) begin
      m_idle = 0;
      if (fe)                               begin m_win = 3; m_over = 1'b1; m_phase = 2; end
      else if (has_line(mmask(1)))          begin m_win = 1; m_over = 1'b1; m_phase = 2; end
      else if (has_line(mmask(2)))          begin m_win = 2; m_over = 1'b1; m_phase = 2; end
      else if ((mmask(1) | mmask(2)) == 9'h1FF) begin m_win = 0; m_over = 1'b1; m_phase = 2; end
      else begin m_turn = !m_turn; m_phase = 0; end
    end else begin
      m_idle = 0;
    end
  endtask

  // Called just after a rising edge: drives one cycle of inputs, steps the model, returns after the next edge.
  task automatic cycle(input bit ng, input bit mv, input logic [3:0] p, input bit fe);
    new_game = ng; move_valid = mv; move_pos = p; force_err = fe;
    #1;
    obs_ready = move_ready;
    exp_ready = (m_phase == 0) && !ng;
    model_step(ng, mv, int'(p), fe);
    @(posedge clk);
    #1;
    new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0; force_err = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (x !== 9'h0)        begin n_fail++; $display("FAIL reset_x: got %h expected %h", x, 9'h0); end
    n_cmp++; if (o !== 9'h0)        begin n_fail++; $display("FAIL reset_o: got %h expected %h", o, 9'h0); end
    n_cmp++; if (turn !== 1'b0)     begin n_fail++; $display("FAIL reset_turn: got %b expected 0", turn); end
    n_cmp++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
    n_cmp++; if (winner !== 2'b00)  begin n_fail++; $display("FAIL reset_winner: got %b expected 00", winner); end
    n_cmp++; if ({move_ack, move_rej, timeout} !== 3'b000)
      begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {move_ack, move_rej, timeout}); end
    n_cmp++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", move_ready); end
  endtask

  task automatic test_x_win();
    int seq [5] = '{4, 0, 2, 8, 6};
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    foreach (seq[i]) begin
      cycle(1'b0, 1'b1, 4'(seq[i]), 1'b0);
      n_cmp++; if (move_ack !== 1'b1) begin n_fail++; $display("FAIL xwin_ack move %0d: got %b expected 1", i, move_ack); end
      cycle(1'b0, 1'b0, 4'd0, 1'b0);
    end
    n_cmp++; if (x !== 9'h054)       begin n_fail++; $display("FAIL xwin_x: got %h expected 054", x); end
    n_cmp++; if (winner !== 2'b01)   begin n_fail++; $display("FAIL xwin_winner: got %b expected 01", winner); end
    n_cmp++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL xwin_game_over: got %b expected 1", game_over); end
    n_cmp++; if (move_ready !== 1'b0) begin n_fail++; $display("FAIL xwin_ready: got %b expected 0", move_ready); end
  endtask

  task automatic test_reject();
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    n_cmp++; if ({move_ack, move_rej} !== 2'b01) begin n_fail++; $display("FAIL rej_occ: got ack/rej %b expected 01", {move_ack, move_rej}); end
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL rej_occ_ready: got %b expected 1", obs_ready); end
    cycle(1'b0, 1'b1, 4'd12, 1'b0);
    n_cmp++; if ({move_ack, move_rej} !== 2'b01) begin n_fail++; $display("FAIL rej_range: got ack/rej %b expected 01", {move_ack, move_rej}); end
    n_cmp++; if ({x, o} !== {9'h010, 9'h000}) begin n_fail++; $display("FAIL rej_board: got x=%h o=%h expected x=010 o=000", x, o); end
    n_cmp++; if (turn !== 1'b1) begin n_fail++; $display("FAIL rej_turn: got %b expected 1", turn); end
    n_cmp++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL rej_ready: got %b expected 1", move_ready); end
  endtask

  task automatic test_draw();
    int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    foreach (seq[i]) begin
      cycle(1'b0, 1'b1, 4'(seq[i]), 1'b0);
      n_cmp++; if (move_ack !== 1'b1) begin n_fail++; $display("FAIL draw_ack move %0d: got %b expected 1", i, move_ack); end
      cycle(1'b0, 1'b0, 4'd0, 1'b0);
    end
    n_cmp++; if ({x, o} !== {9'h18D, 9'h072}) begin n_fail++; $display("FAIL draw_board: got x=%h o=%h expected x=18d o=072", x, o); end
    n_cmp++; if (winner !== 2'b00)   begin n_fail++; $display("FAIL draw_winner: got %b expected 00", winner); end
    n_cmp++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL draw_game_over: got %b expected 1", game_over); end
    n_cmp++; if (move_ready !== 1'b0) begin n_fail++; $display("FAIL draw_ready: got %b expected 0", move_ready); end
  endtask

  task automatic test_error_then_new_game();
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    n_cmp++; if ({game_over, winner} !== 3'b111) begin n_fail++; $display("FAIL err_winner: got over/winner %b expected 111", {game_over, winner}); end
    cycle(1'b1, 1'b1, 4'd0, 1'b0);
    n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL ng_ready: got %b expected 0", obs_ready); end
    n_cmp++; if ({move_ack, move_rej} !== 2'b00) begin n_fail++; $display("FAIL ng_pulses: got ack/rej %b expected 00", {move_ack, move_rej}); end
    n_cmp++; if ({x, o} !== 18'h0) begin n_fail++; $display("FAIL ng_board: got x=%h o=%h expected 0", x, o); end
    n_cmp++; if ({turn, game_over, winner} !== 4'b0000) begin n_fail++; $display("FAIL ng_state: got turn/over/winner %b expected 0000", {turn, game_over, winner}); end
  endtask

  task automatic test_timeout();
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
`ifdef TURN_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      cycle(1'b0, 1'b0, 4'd0, 1'b0);
      n_cmp++; if (timeout !== (k == TO)) begin n_fail++; $display("FAIL to_pulse idle %0d: got %b expected %b", k, timeout, k == TO); end
    end
    n_cmp++; if (turn !== 1'b1) begin n_fail++; $display("FAIL to_turn: got %b expected 1", turn); end
    n_cmp++; if ({x, o} !== 18'h0) begin n_fail++; $display("FAIL to_board: got x=%h o=%h expected 0", x, o); end
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_one_shot: got %b expected 0", timeout); end
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k < TO; k++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd0, 1'b0);
    n_cmp++; if ({move_ack, timeout} !== 2'b10) begin n_fail++; $display("FAIL to_move_wins: got ack/timeout %b expected 10", {move_ack, timeout}); end
    n_cmp++; if (x !== 9'h001) begin n_fail++; $display("FAIL to_move_x: got %h expected 001", x); end
`else
    for (int k = 1; k <= TO + 2; k++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    n_cmp++; if ({timeout, turn} !== 2'b00) begin n_fail++; $display("FAIL noto: got timeout/turn %b expected 00", {timeout, turn}); end
`endif
  endtask

  task automatic test_reset_in_check();
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({x, o} !== 18'h0) begin n_fail++; $display("FAIL arst_board: got x=%h o=%h expected 0", x, o); end
    n_cmp++; if ({turn, game_over, winner, move_ack, move_rej, timeout} !== 7'b0)
      begin n_fail++; $display("FAIL arst_outputs: got %b expected 0000000", {turn, game_over, winner, move_ack, move_rej, timeout}); end
    n_cmp++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b expected 1", move_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, 4'd0, 1'b0);
    n_cmp++; if ({move_ack, x} !== {1'b1, 9'h001}) begin n_fail++; $display("FAIL arst_play: got ack=%b x=%h expected ack=1 x=001", move_ack, x); end
  endtask

  task automatic test_random();
    bit ng, mv, fe;
    logic [3:0] p;
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      ng = ($urandom_range(0, 24) == 0);
      mv = $urandom_range(0, 1);
      p  = 4'($urandom_range(0, 11));
      fe = ($urandom_range(0, 19) == 0);
      cycle(ng, mv, p, fe);
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", i, obs_ready, exp_ready); end
      n_cmp++; if (move_ack !== m_ack) begin n_fail++; $display("FAIL rnd_ack cyc %0d: got %b expected %b", i, move_ack, m_ack); end
      n_cmp++; if (move_rej !== m_rej) begin n_fail++; $display("FAIL rnd_rej cyc %0d: got %b expected %b", i, move_rej, m_rej); end
      n_cmp++; if (timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout cyc %0d: got %b expected %b", i, timeout, m_to); end
      n_cmp++; if (x !== mmask(1)) begin n_fail++; $display("FAIL rnd_x cyc %0d: got %h expected %h", i, x, mmask(1)); end
      n_cmp++; if (o !== mmask(2)) begin n_fail++; $display("FAIL rnd_o cyc %0d: got %h expected %h", i, o, mmask(2)); end
      n_cmp++; if (turn !== m_turn) begin n_fail++; $display("FAIL rnd_turn cyc %0d: got %b expected %b", i, turn, m_turn); end
      n_cmp++; if (game_over !== m_over) begin n_fail++; $display("FAIL rnd_over cyc %0d: got %b expected %b", i, game_over, m_over); end
      n_cmp++; if (winner !== 2'(m_win)) begin n_fail++; $display("FAIL rnd_winner cyc %0d: got %b expected %b", i, winner, 2'(m_win)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0; force_err = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_x_win();
    test_reject();
    test_draw();
    test_error_then_new_game();
    test_timeout();
    test_reset_in_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
